// File: rtl/demux_1_4_stream_if.sv
// Stream bus for the 1-to-4 demultiplexer: one input stream, four output channels and their
// transfer counters. The master modport drives stimulus; the slave modport is the demux itself.
interface demux_1_4_stream_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  logic [1:0]       sel;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic [WIDTH-1:0] out_data3;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic [CNT_W-1:0] cnt2;
  logic [CNT_W-1:0] cnt3;

  modport master (
    output sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
    input  cnt0, cnt1, cnt2, cnt3
  );

  modport slave (
    input  sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
    output cnt0, cnt1, cnt2, cnt3
  );
endinterface

// File: rtl/demux_1_4_stream.sv
// 1-to-4 stream demultiplexer: each channel is a one-entry holding register that can drain and
// reload in the same cycle, with a free-running wrap-around count of completed output transfers.
module demux_1_4_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input logic               clk,
  input logic               rst,
  demux_1_4_stream_if.slave bus
);

  typedef enum logic {StEmpty, StFull} ch_state_e;

  ch_state_e        state_q [4];
  ch_state_e        state_d [4];
  logic [WIDTH-1:0] data_q  [4];
  logic [WIDTH-1:0] data_d  [4];
  logic [CNT_W-1:0] cnt_q   [4];
  logic [CNT_W-1:0] cnt_d   [4];

  logic [3:0] full;
  logic       in_ready;
  logic       accept;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      full[k] = (state_q[k] == StFull);
    end
  end

  // Ready looks only at the selected channel, so it follows sel even with no word offered.
  assign in_ready = !rst && (!full[bus.sel] || bus.out_ready[bus.sel]);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      state_d[k] = state_q[k];
      data_d[k]  = data_q[k];
      cnt_d[k]   = cnt_q[k];
      if (full[k] && bus.out_ready[k]) begin
        state_d[k] = StEmpty;
        cnt_d[k]   = cnt_q[k] + CNT_W'(1);
      end
      // A load after the drain keeps the channel full with no bubble.
      if (accept && (bus.sel == 2'(k))) begin
        state_d[k] = StFull;
        data_d[k]  = bus.in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= StEmpty;
        data_q[k]  <= '0;
        cnt_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= state_d[k];
        data_q[k]  <= data_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = full;
  assign bus.out_data0 = data_q[0];
  assign bus.out_data1 = data_q[1];
  assign bus.out_data2 = data_q[2];
  assign bus.out_data3 = data_q[3];
  assign bus.cnt0      = cnt_q[0];
  assign bus.cnt1      = cnt_q[1];
  assign bus.cnt2      = cnt_q[2];
  assign bus.cnt3      = cnt_q[3];

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Bench for demux_1_4_stream: directed vector table, multi-cycle corner sequences and a
// model-checked random run.
module tb_demux_1_4_stream;

  logic clk;
  logic rst;

  demux_1_4_stream_if #(.WIDTH(8), .CNT_W(8)) bus ();

  demux_1_4_stream #(.WIDTH(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  sel;
    logic        vld;
    logic [7:0]  data;
    logic [3:0]  ordy;
    logic        e_rdy;
    logic [3:0]  e_ov;
    logic [31:0] e_data;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs [9];

  logic       mv [4];
  logic [7:0] md [4];
  logic [7:0] mc [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] s, input logic v, input logic [7:0] d,
                       input logic [3:0] o);
    rst           = r;
    bus.sel       = s;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = o;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_data();
    return {bus.out_data3, bus.out_data2, bus.out_data1, bus.out_data0};
  endfunction

  function automatic logic [31:0] all_cnt();
    return {bus.cnt3, bus.cnt2, bus.cnt1, bus.cnt0};
  endfunction

  task automatic do_reset();
    drive(1'b1, 2'd0, 1'b0, 8'h00, 4'h0);
    tick();
    drive(1'b0, 2'd0, 1'b0, 8'h00, 4'h0);
  endtask

  initial begin
    // Reset with live-looking inputs: ready must stay low, state must clear.
    drive(1'b1, 2'd2, 1'b1, 8'hEE, 4'hF);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("reset_in_ready_late", 32'(bus.in_ready), 32'd0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
    chk("reset_data", all_data(), 32'h0);
    chk("reset_cnt", all_cnt(), 32'h0);
    drive(1'b0, 2'd0, 1'b0, 8'h00, 4'h0);
    chk("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

    vecs[0] = '{2'd2, 1'b1, 8'hA5, 4'b0000, 1'b1, 4'b0100, 32'h00A50000, 32'h00000000};
    vecs[1] = '{2'd1, 1'b1, 8'h11, 4'b0000, 1'b1, 4'b0110, 32'h00A51100, 32'h00000000};
    vecs[2] = '{2'd1, 1'b1, 8'h22, 4'b0000, 1'b0, 4'b0110, 32'h00A51100, 32'h00000000};
    vecs[3] = '{2'd3, 1'b1, 8'h33, 4'b0000, 1'b1, 4'b1110, 32'h33A51100, 32'h00000000};
    vecs[4] = '{2'd0, 1'b0, 8'hFF, 4'b0000, 1'b1, 4'b1110, 32'h33A51100, 32'h00000000};
    vecs[5] = '{2'd0, 1'b1, 8'h01, 4'b0000, 1'b1, 4'b1111, 32'h33A51101, 32'h00000000};
    vecs[6] = '{2'd0, 1'b1, 8'h02, 4'b0001, 1'b1, 4'b1111, 32'h33A51102, 32'h00000001};
    vecs[7] = '{2'd2, 1'b0, 8'h00, 4'b0110, 1'b1, 4'b1001, 32'h33A51102, 32'h00010101};
    vecs[8] = '{2'd1, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h33A51102, 32'h01010102};

    for (int i = 0; i < 9; i++) begin
      drive(1'b0, vecs[i].sel, vecs[i].vld, vecs[i].data, vecs[i].ordy);
      chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_rdy));
      tick();
      chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d_data", i), all_data(), vecs[i].e_data);
      chk($sformatf("vec%0d_cnt", i), all_cnt(), vecs[i].e_cnt);
    end

    // Counter wrap on channel 3: load then drain, 256 times.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 2'd3, 1'b1, 8'(i), 4'b0000);
      tick();
      drive(1'b0, 2'd3, 1'b0, 8'h00, 4'b1000);
      tick();
      if (i == 254) chk("wrap_cnt3_255", 32'(bus.cnt3), 32'd255);
    end
    chk("wrap_cnt3_zero", 32'(bus.cnt3), 32'd0);
    chk("wrap_other_cnts", 32'({bus.cnt2, bus.cnt1, bus.cnt0}), 32'd0);
    chk("wrap_out_valid", 32'(bus.out_valid), 32'h0);
    chk("wrap_data_kept", 32'(bus.out_data3), 32'hFF);

    // Reset mid-operation with every channel full and all consumers ready.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 2'(k), 1'b1, 8'(8'h10 + k), 4'b0000);
      tick();
    end
    chk("fill_out_valid", 32'(bus.out_valid), 32'hF);
    chk("fill_data", all_data(), 32'h13121110);
    drive(1'b0, 2'd0, 1'b1, 8'h55, 4'b0001);
    tick();
    chk("pre_reset_cnt", all_cnt(), 32'h00000001);
    chk("pre_reset_data", all_data(), 32'h13121155);
    drive(1'b1, 2'd0, 1'b1, 8'h77, 4'hF);
    chk("mid_reset_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("mid_reset_out_valid", 32'(bus.out_valid), 32'h0);
    chk("mid_reset_cnt", all_cnt(), 32'h0);
    chk("mid_reset_data", all_data(), 32'h0);
    drive(1'b0, 2'd0, 1'b0, 8'h00, 4'h0);
    chk("after_reset_in_ready", 32'(bus.in_ready), 32'd1);

    // Random stress against an independent per-channel model.
    for (int k = 0; k < 4; k++) begin
      mv[k] = 1'b0;
      md[k] = 8'h00;
      mc[k] = 8'h00;
    end
    for (int i = 0; i < 1000; i++) begin
      logic [1:0] s;
      logic       v;
      logic [7:0] d;
      logic [3:0] o;
      logic       er;
      logic [3:0] eov;
      s = 2'($urandom_range(3));
      v = 1'($urandom_range(1));
      d = 8'($urandom);
      o = 4'($urandom_range(15));
      drive(1'b0, s, v, d, o);
      er = !mv[s] || o[s];
      chk("rand_in_ready", 32'(bus.in_ready), 32'(er));
      tick();
      for (int k = 0; k < 4; k++) begin
        if (mv[k] && o[k]) begin
          mv[k] = 1'b0;
          mc[k] = mc[k] + 8'd1;
        end
        if (v && er && (s == 2'(k))) begin
          mv[k] = 1'b1;
          md[k] = d;
        end
        eov[k] = mv[k];
      end
      chk("rand_out_valid", 32'(bus.out_valid), 32'(eov));
      chk("rand_data", all_data(), {md[3], md[2], md[1], md[0]});
      chk("rand_cnt", all_cnt(), {mc[3], mc[2], mc[1], mc[0]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
